hex_tx_sequencer: RTL and testbench
===================================

// Module: hex_tx_sequencer
// PURPOSE
//  Streams a stored image from the single-port RAM out through the UART transmitter.
//  On start it reads RAM words from address 0 upward and hands each byte to the UART TX.
//  It stops at the END_MARKER word or at the end of the memory.
//  Sits in top between single_port_ram_with_init and uart; it owns the RAM address bus
//  and the UART start_tx_i/serial_write_i inputs.
// PARAMETERS
//  ADDR_W      10      RAM address width
//  DATA_W      10      RAM word width (>= 9)
//  MEM_DEPTH   1000    number of valid RAM words; last address = MEM_DEPTH-1
//  END_MARKER  10'h1FF word value that terminates the stream; this word is not sent
//  RAM_LAT     1       RAM read latency in clocks (addr -> q valid)
// PORTS
//  CLK_UART_i       in   1        system/UART clock
//  rst_n_i          in   1        reset; one clock; reset is asynchronous and active-low
//  start_i          in   1        start request, active high; rising edge detected internally
//  abort_i          in   1        synchronous abort, active high
//  ram_addr_o       out  ADDR_W   RAM read address
//  ram_we_o         out  1        RAM write enable; constant 0
//  ram_q_i          in   DATA_W   RAM read data
//  uart_busy_tx_i   in   1        UART busy_tx_o
//  uart_start_tx_o  out  1        UART start_tx_i; held until busy is acknowledged
//  uart_data_o      out  8        UART serial_write_i; low 8 bits of current word
//  busy_o           out  1        high from accepted start until return to IDLE
//  done_o           out  1        1-cycle pulse at normal end (marker found)
//  overflow_o       out  1        1-cycle pulse if MEM_DEPTH words sent without marker
//  sent_count_o     out  ADDR_W+1 bytes sent in current/last run
// BEHAVIOUR
//  Reset (async, rst_n_i=0):
//   - state=IDLE; all outputs 0; the start edge-detect register is cleared.
//  FSM states: IDLE, FETCH, CHECK, REQ, ACK, DRAIN, DONE.
//  IDLE:
//   - A start_i rising edge loads addr=0 and sent_count=0, then -> FETCH.
//   - A start_i held high does not restart after the run ends; a new edge is required.
//  FETCH:
//   - Drive ram_addr_o and wait RAM_LAT cycles, then register ram_q_i -> CHECK.
//  CHECK:
//   - word==END_MARKER -> DONE with done_o.
//   - Otherwise latch uart_data_o = word[7:0] -> REQ.
//  REQ:
//   - Assert uart_start_tx_o only when uart_busy_tx_i=0.
//   - Keep it asserted until uart_busy_tx_i=1 is seen, then deassert -> ACK.
//  ACK/DRAIN:
//   - Wait for uart_busy_tx_i=0, then sent_count+=1.
//   - If addr==MEM_DEPTH-1 -> DONE with overflow_o; otherwise addr+=1 -> FETCH.
//   - The address never wraps.
//  DONE:
//   - One cycle; pulses done_o or overflow_o (never both) -> IDLE.
//  Stability and counts:
//   - uart_data_o is stable from REQ entry until DRAIN exit.
//   - sent_count_o holds its value in IDLE until the next start.
//  Latency:
//   - Start edge to first uart_start_tx_o = 3+RAM_LAT clocks when the UART is idle.
//  Abort:
//   - abort_i in any non-IDLE state -> IDLE next cycle; uart_start_tx_o drops immediately.
//   - The byte in flight completes inside the UART; no done_o or overflow_o pulse.
//   - abort_i wins over a simultaneous start edge.
//  Boundary cases:
//   - A marker at address 0 ends the run with done_o and sent_count=0.
//   - A start edge while busy_o=1 is ignored.
//   - A UART already busy at REQ entry delays the request; no byte is lost.
// TESTING
//  - Stream: RAM={41,42,43,1FF}, start -> UART receives 41,42,43; done_o pulse; sent_count_o=3.
//  - Empty image: RAM[0]=1FF, start -> no uart_start_tx_o; done_o 4+RAM_LAT clocks after edge; count=0.
//  - No marker: MEM_DEPTH=4, RAM={01,02,03,04} -> 4 bytes; overflow_o=1; done_o=0; ram_addr_o max 3.
//  - Abort: assert abort_i during byte 2 of 5 -> IDLE next clock; busy_o=0; no pulses; restart sends from addr 0.
//  - Handshake: UART model delays busy by 3 clocks -> uart_start_tx_o stays high those 3 clocks; exactly one byte sent per word.
//  - Reset mid-run: rst_n_i low asynchronously in DRAIN -> all outputs 0 at once; held start_i does not retrigger.

Source files
------------

// File: rtl/hex_tx_sequencer.sv
// Streams RAM words from address 0 upward into the UART transmitter, one low byte per word,
// stopping at the end-marker word or after the last valid address.
module hex_tx_sequencer #(
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 10,
  parameter int                MEM_DEPTH  = 1000,
  parameter logic [DATA_W-1:0] END_MARKER = DATA_W'(10'h1FF),
  parameter int                RAM_LAT    = 1
) (
  input  logic              CLK_UART_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_q_i,
  input  logic              uart_busy_tx_i,
  output logic              uart_start_tx_o,
  output logic [7:0]        uart_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   sent_count_o
);

  localparam int                LAT_W     = (RAM_LAT < 1) ? 1 : $clog2(RAM_LAT + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RAM_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_REQ, S_ACK, S_DRAIN, S_DONE
  } state_t;

  state_t              r_state;
  logic                r_start_lo;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_word;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic                r_start_tx;
  logic [7:0]          r_data;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic                r_end_ovf;
  logic [ADDR_W:0]     r_count;
  logic                w_start_edge;

  // r_start_lo records that start_i was seen low, so a start held through reset cannot fire.
  assign w_start_edge = start_i & r_start_lo;

  always_ff @(posedge CLK_UART_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_start_lo <= 1'b0;
      r_addr     <= '0;
      r_word     <= '0;
      r_lat_cnt  <= '0;
      r_start_tx <= 1'b0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_end_ovf  <= 1'b0;
      r_count    <= '0;
    end else begin
      r_start_lo <= ~start_i;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      if (abort_i && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_start_tx <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_edge && !abort_i) begin
              r_addr    <= '0;
              r_count   <= '0;
              r_lat_cnt <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (r_lat_cnt == LAT_LAST) begin
              r_word  <= ram_q_i;
              r_state <= S_CHECK;
            end else begin
              r_lat_cnt <= r_lat_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            if (r_word == END_MARKER) begin
              r_end_ovf <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_data     <= r_word[7:0];
              r_start_tx <= ~uart_busy_tx_i;
              r_state    <= S_REQ;
            end
          end
          S_REQ: begin
            // Request is held until the UART shows busy; a UART busy beforehand just delays it.
            if (r_start_tx && uart_busy_tx_i) begin
              r_start_tx <= 1'b0;
              r_state    <= S_ACK;
            end else if (!uart_busy_tx_i) begin
              r_start_tx <= 1'b1;
            end
          end
          S_ACK: begin
            r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (!uart_busy_tx_i) begin
              r_count <= r_count + 1'b1;
              if (r_addr == LAST_ADDR) begin
                r_end_ovf <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_addr    <= r_addr + 1'b1;
                r_lat_cnt <= '0;
                r_state   <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            r_done  <= ~r_end_ovf;
            r_ovf   <= r_end_ovf;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ram_addr_o      = r_addr;
  assign ram_we_o        = 1'b0;
  assign uart_start_tx_o = r_start_tx;
  assign uart_data_o     = r_data;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign overflow_o      = r_ovf;
  assign sent_count_o    = r_count;

endmodule

// File: tb/tb_hex_tx_sequencer.sv
// Directed bench for hex_tx_sequencer with a 1-clock RAM model and a simple UART busy model.
module tb_hex_tx_sequencer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q = '0;
  logic              uart_start;
  logic [7:0]        uart_data;
  logic              busy_o, done_o, overflow_o;
  logic [ADDR_W:0]   sent_count;

  logic              u_busy = 1'b0;
  logic              ext_busy = 1'b0;
  logic              w_busy;
  int                u_st = 0;
  int                u_cnt = 0;
  int                busy_dly = 1;
  int                tx_len = 4;

  logic [DATA_W-1:0] mem [0:1023];
  logic [7:0]        rxq [$];

  int n_chk = 0, n_err = 0;
  int n_done = 0, n_ovf = 0, n_req_wait = 0, n_start_hi = 0;
  int max_addr = 0;

  assign w_busy = u_busy | ext_busy;

  hex_tx_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH),
    .END_MARKER(10'h1FF), .RAM_LAT(1)
  ) dut (
    .CLK_UART_i(clk), .rst_n_i(rst_n), .start_i(start_i), .abort_i(abort_i),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_q_i(ram_q),
    .uart_busy_tx_i(w_busy), .uart_start_tx_o(uart_start), .uart_data_o(uart_data),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o), .sent_count_o(sent_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_addr];

  // UART model: captures the byte when it sees start, raises busy busy_dly clocks after
  // start rose, and holds busy for tx_len clocks.
  always @(posedge clk) begin
    case (u_st)
      0: if (uart_start && !ext_busy) begin
           rxq.push_back(uart_data);
           if (busy_dly <= 1) begin
             u_busy <= 1'b1; u_cnt = tx_len; u_st = 2;
           end else begin
             u_cnt = busy_dly - 1; u_st = 1;
           end
         end
      1: begin
           u_cnt--;
           if (u_cnt == 0) begin u_busy <= 1'b1; u_cnt = tx_len; u_st = 2; end
         end
      default: begin
           u_cnt--;
           if (u_cnt == 0) begin u_busy <= 1'b0; u_st = 0; end
         end
    endcase
  end

  always @(negedge clk) begin
    if (done_o) n_done++;
    if (overflow_o) n_ovf++;
    if (uart_start) n_start_hi++;
    if (uart_start && !w_busy) n_req_wait++;
    if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rx_pack();
    logic [63:0] v = '0;
    foreach (rxq[i]) v = (v << 8) | 64'(rxq[i]);
    return v;
  endfunction

  task automatic clear_stats();
    rxq.delete();
    n_done = 0; n_ovf = 0; n_req_wait = 0; n_start_hi = 0; max_addr = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop start for two clocks, then raise it 1 time unit after a rising edge.
  task automatic kick();
    start_i = 1'b0;
    cycles(2);
    start_i = 1'b1;
  endtask

  // Clocks from the start edge until the selected output is seen (0=start_tx, 1=done_o).
  task automatic lat_to(input int which, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!((which == 0) ? uart_start : done_o) && n < 40);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(done_o || overflow_o) && n < 400);
    if (!(done_o || overflow_o)) chk({tag, "_timeout"}, 0, 1);
    n = 0;
    while ((u_st != 0 || u_busy) && n < 100) begin @(negedge clk); n++; end
    cycles(2);
  endtask

  task automatic set_image(input logic [DATA_W-1:0] w0, w1, w2, w3, w4, w5, w6);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    mem[4] = w4; mem[5] = w5; mem[6] = w6;
  endtask

  initial begin
    int lat;
    int n;
    int rx_before;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    cycles(3);
    chk("reset_outputs", {ram_addr, uart_start, uart_data, busy_o, done_o, overflow_o, sent_count}, '0);
    chk("reset_we", ram_we, 0);
    rst_n = 1'b1;
    cycles(2);

    // Stream 41,42,43 then marker
    set_image(10'h041, 10'h042, 10'h043, 10'h1FF, 10'h000, 10'h000, 10'h000);
    clear_stats();
    kick();
    lat_to(0, lat);
    chk("stream_start_latency", lat, 4);
    wait_end("stream");
    chk("stream_bytes", rx_pack(), 64'h414243);
    chk("stream_done_pulses", n_done, 1);
    chk("stream_no_ovf", n_ovf, 0);
    chk("stream_count", sent_count, 3);
    chk("stream_one_wait_per_byte", n_req_wait, 3);
    cycles(20);
    chk("stream_held_start_idle", busy_o, 0);
    chk("stream_no_restart", rxq.size(), 3);
    chk("stream_count_holds", sent_count, 3);

    // Empty image: marker at address 0
    set_image(10'h1FF, 10'h041, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000);
    clear_stats();
    kick();
    lat_to(1, lat);
    chk("empty_done_latency", lat, 5);
    cycles(3);
    chk("empty_no_start", n_start_hi, 0);
    chk("empty_count", sent_count, 0);
    chk("empty_done_pulses", n_done, 1);

    // No marker: all DEPTH words sent, overflow instead of done
    set_image(10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h1FF);
    clear_stats();
    kick();
    wait_end("nomark");
    chk("nomark_bytes", rx_pack(), 64'h010203040506);
    chk("nomark_ovf", n_ovf, 1);
    chk("nomark_no_done", n_done, 0);
    chk("nomark_max_addr", max_addr, DEPTH - 1);
    chk("nomark_count", sent_count, DEPTH);

    // Abort during byte 2 of 5, then restart from address 0
    set_image(10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h1FF, 10'h000);
    clear_stats();
    kick();
    n = 0;
    while (rxq.size() < 2 && n < 200) begin @(negedge clk); n++; end
    chk("abort_reached_byte2", rxq.size(), 2);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_busy_low", busy_o, 0);
    chk("abort_start_low", uart_start, 0);
    cycles(20);
    chk("abort_no_pulses", n_done + n_ovf, 0);
    chk("abort_stays_idle", busy_o, 0);
    clear_stats();
    kick();
    wait_end("restart");
    chk("restart_bytes", rx_pack(), 64'h1112131415);
    chk("restart_done", n_done, 1);
    chk("restart_count", sent_count, 5);

    // Slow handshake: busy rises 3 clocks after start
    set_image(10'h0A1, 10'h0B2, 10'h0C3, 10'h1FF, 10'h000, 10'h000, 10'h000);
    busy_dly = 3;
    clear_stats();
    kick();
    wait_end("hshake");
    chk("hshake_wait_cycles", n_req_wait, 9);
    chk("hshake_bytes", rx_pack(), 64'hA1B2C3);
    busy_dly = 1;

    // UART already busy when the first request is due
    set_image(10'h041, 10'h042, 10'h043, 10'h1FF, 10'h000, 10'h000, 10'h000);
    ext_busy = 1'b1;
    clear_stats();
    kick();
    cycles(12);
    chk("extbusy_no_start", n_start_hi, 0);
    chk("extbusy_no_rx", rxq.size(), 0);
    ext_busy = 1'b0;
    wait_end("extbusy");
    chk("extbusy_bytes", rx_pack(), 64'h414243);
    chk("extbusy_count", sent_count, 3);

    // Asynchronous reset in DRAIN with start held high
    set_image(10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h1FF, 10'h000);
    clear_stats();
    kick();
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(w_busy && !uart_start && busy_o) && n < 200);
    chk("rst_reached_drain", w_busy && !uart_start && busy_o, 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {ram_addr, uart_start, uart_data, busy_o, done_o, overflow_o, sent_count}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_before = rxq.size();
    cycles(30);
    chk("rst_no_retrigger", busy_o, 0);
    chk("rst_no_new_bytes", rxq.size(), rx_before);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
